// File: rtl/codasip_memory_mem_rw_arbiter_pkg.sv
// Shared types and widths for the mem read_write port arbiter.
package codasip_memory_mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SI_W   = 2;
    localparam int SC_W   = 3;
    localparam int CMD_W  = 3;
    localparam int RESP_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_IDLE  = 3'd0,
        CMD_READ  = 3'd1,
        CMD_WRITE = 3'd2
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_WAIT = 3'd0,
        RESP_ACK  = 3'd1,
        RESP_ERR  = 3'd2
    } resp_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA_RD,
        S_DATA_WR
    } state_e;

endpackage

// File: rtl/codasip_memory_mem_rw_arbiter_if.sv
// Requester-side and memory-side REQ/IF/OF bus bundle for the mem port arbiter.
interface codasip_memory_mem_rw_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import codasip_memory_mem_arb_pkg::*;

    logic [NUM_REQ-1:0][ADDR_W-1:0] rq_A0;
    logic [NUM_REQ-1:0][SI_W-1:0]   rq_SI0;
    logic [NUM_REQ-1:0][SC_W-1:0]   rq_SC0;
    logic [NUM_REQ-1:0][CMD_W-1:0]  rq_REQCMD0;
    logic [NUM_REQ-1:0][RESP_W-1:0] rq_REQRESP0;
    logic [NUM_REQ-1:0][CMD_W-1:0]  rq_IFCMD0;
    logic [NUM_REQ-1:0][RESP_W-1:0] rq_IFRESP0;
    logic [NUM_REQ-1:0][DATA_W-1:0] rq_Q0;
    logic [NUM_REQ-1:0][DATA_W-1:0] rq_D0;
    logic [NUM_REQ-1:0][CMD_W-1:0]  rq_OFCMD0;
    logic [NUM_REQ-1:0][RESP_W-1:0] rq_OFRESP0;

    logic [ADDR_W-1:0] mem_A0;
    logic [SI_W-1:0]   mem_SI0;
    logic [SC_W-1:0]   mem_SC0;
    logic [CMD_W-1:0]  mem_REQCMD0;
    logic [CMD_W-1:0]  mem_IFCMD0;
    logic [DATA_W-1:0] mem_D0;
    logic [CMD_W-1:0]  mem_OFCMD0;
    logic [RESP_W-1:0] mem_REQRESP0;
    logic [RESP_W-1:0] mem_IFRESP0;
    logic [RESP_W-1:0] mem_OFRESP0;
    logic [DATA_W-1:0] mem_Q0;

    // Arbiter view
    modport slave (
        input  rq_A0, rq_SI0, rq_SC0, rq_REQCMD0, rq_IFCMD0, rq_D0, rq_OFCMD0,
        input  mem_REQRESP0, mem_IFRESP0, mem_OFRESP0, mem_Q0,
        output rq_REQRESP0, rq_IFRESP0, rq_Q0, rq_OFRESP0,
        output mem_A0, mem_SI0, mem_SC0, mem_REQCMD0, mem_IFCMD0, mem_D0, mem_OFCMD0
    );

    // Environment view: requesters plus the memory
    modport master (
        output rq_A0, rq_SI0, rq_SC0, rq_REQCMD0, rq_IFCMD0, rq_D0, rq_OFCMD0,
        output mem_REQRESP0, mem_IFRESP0, mem_OFRESP0, mem_Q0,
        input  rq_REQRESP0, rq_IFRESP0, rq_Q0, rq_OFRESP0,
        input  mem_A0, mem_SI0, mem_SC0, mem_REQCMD0, mem_IFCMD0, mem_D0, mem_OFCMD0
    );

endinterface

// File: rtl/codasip_memory_mem_rw_arbiter_picker.sv
// Combinational round-robin one-hot select, searching from last_i+1 upward.
module codasip_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);
    int   cand;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_i) + i) % NUM_REQ;
            if (!found && req_i[IDX_W'(cand)]) begin
                gnt_o[IDX_W'(cand)] = 1'b1;
                idx_o               = IDX_W'(cand);
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/codasip_memory_mem_rw_arbiter.sv
// Round-robin arbiter sharing mem's read_write port; a transaction stays locked to one requester.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN.
//   state     | meaning
//   S_IDLE    | no owner, arbitrate among pending requests
//   S_ADDR    | owner's address phase routed to memory
//   S_DATA_RD | owner's read-data phase (IF) routed
//   S_DATA_WR | owner's write-data phase (OF) routed
module codasip_memory_mem_rw_arbiter
    import codasip_memory_mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           CLK,
    input  logic                           RST,
    codasip_memory_mem_rw_arbiter_if.slave bus,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           timeout_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   last_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               expire;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = (bus.rq_REQCMD0[i] != CMD_IDLE);
        end
    end

    codasip_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i  (req_vec),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             addr_done;

    // Clearing on the address ACK restarts the count for the data phase.
    assign addr_done = (state_q == S_ADDR) && (bus.mem_REQRESP0 == RESP_ACK);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE || addr_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire = (state_q != S_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    // Watchdog compiled out; the parameter is kept so both builds share one interface.
    assign expire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cmd_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_vec) begin
                        grant_q <= pick_gnt;
                        gidx_q  <= pick_idx;
                        cmd_q   <= bus.rq_REQCMD0[pick_idx];
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (expire) begin
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else if (bus.rq_REQCMD0[gidx_q] == CMD_IDLE) begin
                        // Abort leaves last_q alone so the same requester keeps its turn.
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else if (bus.mem_REQRESP0 == RESP_ACK) begin
                        state_q <= (cmd_q == CMD_WRITE) ? S_DATA_WR : S_DATA_RD;
                    end
                end
                S_DATA_RD: begin
                    if (expire || bus.mem_IFRESP0 == RESP_ACK) begin
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_DATA_WR: begin
                    if (expire || bus.mem_OFRESP0 == RESP_ACK) begin
                        last_q  <= gidx_q;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_A0      = '0;
        bus.mem_SI0     = '0;
        bus.mem_SC0     = '0;
        bus.mem_REQCMD0 = '0;
        bus.mem_IFCMD0  = '0;
        bus.mem_D0      = '0;
        bus.mem_OFCMD0  = '0;
        bus.rq_REQRESP0 = '0;
        bus.rq_IFRESP0  = '0;
        bus.rq_OFRESP0  = '0;
        bus.rq_Q0       = '0;
        case (state_q)
            S_ADDR: begin
                bus.mem_A0                  = bus.rq_A0[gidx_q];
                bus.mem_SI0                 = bus.rq_SI0[gidx_q];
                bus.mem_SC0                 = bus.rq_SC0[gidx_q];
                bus.mem_REQCMD0             = expire ? CMD_IDLE : bus.rq_REQCMD0[gidx_q];
                bus.rq_REQRESP0[gidx_q]     = expire ? RESP_ERR : bus.mem_REQRESP0;
            end
            S_DATA_RD: begin
                bus.mem_IFCMD0              = expire ? CMD_IDLE : bus.rq_IFCMD0[gidx_q];
                bus.rq_IFRESP0[gidx_q]      = expire ? RESP_ERR : bus.mem_IFRESP0;
                bus.rq_Q0[gidx_q]           = expire ? '0 : bus.mem_Q0;
            end
            S_DATA_WR: begin
                bus.mem_OFCMD0              = expire ? CMD_IDLE : bus.rq_OFCMD0[gidx_q];
                bus.mem_D0                  = bus.rq_D0[gidx_q];
                bus.rq_OFRESP0[gidx_q]      = expire ? RESP_ERR : bus.mem_OFRESP0;
            end
            default: ;
        endcase
    end

    assign grant_o   = grant_q;
    assign timeout_o = expire;

endmodule

// File: tb/tb_codasip_memory_mem_rw_arbiter.sv
// Testbench for codasip_memory_mem_rw_arbiter: directed vectors, hand sequences, random vs transaction model.
module tb_codasip_memory_mem_rw_arbiter;
    localparam int N = 2;
    localparam logic [2:0] RD = 3'd1, WR = 3'd2;
    localparam logic [2:0] WT = 3'd0, ACK = 3'd1, ERR = 3'd2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] grant_o;
    logic         timeout_o;
    int           n_checks = 0;
    int           n_err = 0;

    codasip_memory_mem_rw_arbiter_if #(.NUM_REQ(N)) bus ();

    codasip_memory_mem_rw_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] c0;
        logic [2:0] c1;
        logic [1:0] gnt;
        logic [2:0] cmd;
    } vec_t;
    vec_t vt[7];

    // random-phase model state
    int          ph[N], wait_cnt[N], others[N], word[N];
    logic [2:0]  rcmd[N];
    logic [31:0] raddr[N], rdata[N];
    logic [31:0] rmod[N][8], mmem[N][8];
    logic [31:0] m_addr;
    int          lat_a, lat_d;
    bit          stop_rand;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        bus.rq_A0 = '0;  bus.rq_SI0 = '0; bus.rq_SC0 = '0; bus.rq_REQCMD0 = '0;
        bus.rq_IFCMD0 = '0; bus.rq_D0 = '0; bus.rq_OFCMD0 = '0;
        bus.mem_REQRESP0 = '0; bus.mem_IFRESP0 = '0; bus.mem_OFRESP0 = '0; bus.mem_Q0 = '0;
    endtask

    task automatic run_vec(input int v);
        int w;
        logic [31:0] q;
        w = vt[v].gnt[1] ? 1 : 0;
        q = 32'hC0DE_0000 + 32'(v);
        bus.rq_A0[0] = 32'h100; bus.rq_A0[1] = 32'h104;
        bus.rq_D0[0] = 32'h11;  bus.rq_D0[1] = 32'h22;
        bus.rq_REQCMD0[0] = vt[v].c0; bus.rq_REQCMD0[1] = vt[v].c1;
        #1 chk($sformatf("v%0d_idle_grant", v), grant_o, 0);
        step();
        chk($sformatf("v%0d_grant", v), grant_o, vt[v].gnt);
        chk($sformatf("v%0d_mem_cmd", v), bus.mem_REQCMD0, vt[v].cmd);
        chk($sformatf("v%0d_mem_addr", v), bus.mem_A0, (w == 1) ? 32'h104 : 32'h100);
        bus.mem_REQRESP0 = ACK;
        #1 chk($sformatf("v%0d_resp_route", v), {bus.rq_REQRESP0[w], bus.rq_REQRESP0[1-w]}, {ACK, WT});
        step();
        bus.mem_REQRESP0 = WT; bus.rq_REQCMD0 = '0;
        if (vt[v].cmd == RD) begin
            bus.rq_IFCMD0[w] = RD; bus.mem_IFRESP0 = ACK; bus.mem_Q0 = q;
            #1 chk($sformatf("v%0d_rd_q", v), {bus.rq_Q0[w], bus.rq_Q0[1-w]}, {q, 32'h0});
        end else begin
            bus.rq_OFCMD0[w] = WR; bus.mem_OFRESP0 = ACK;
            #1 chk($sformatf("v%0d_wr_d", v), {bus.mem_OFCMD0, bus.mem_D0}, {WR, (w == 1) ? 32'h22 : 32'h11});
        end
        step();
        clear_in();
        #1 chk($sformatf("v%0d_end_grant", v), {grant_o, bus.mem_REQCMD0}, 0);
    endtask

    initial begin
        vt[0] = '{RD, 3'd0, 2'b01, RD};
        vt[1] = '{WR, WR,   2'b10, WR};
        vt[2] = '{RD, RD,   2'b01, RD};
        vt[3] = '{RD, RD,   2'b10, RD};
        vt[4] = '{3'd0, WR, 2'b10, WR};
        vt[5] = '{WR, RD,   2'b01, WR};
        vt[6] = '{WR, 3'd0, 2'b01, WR};

        clear_in();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", {grant_o, timeout_o, bus.mem_REQCMD0, bus.rq_REQRESP0}, 0);
        RST = 1'b0;
        step();

        for (int v = 0; v < 7; v++) run_vec(v);

        // read with address ACK delayed two cycles
        bus.rq_A0[0] = 32'h100; bus.rq_REQCMD0[0] = RD;
        step();
        chk("rd_cmd_latency", {bus.mem_REQCMD0, bus.mem_A0}, {RD, 32'h100});
        step();
        chk("rd_wait", bus.rq_REQRESP0[0], WT);
        step();
        bus.mem_REQRESP0 = ACK;
        step();
        bus.mem_REQRESP0 = WT; bus.rq_REQCMD0[0] = 3'd0;
        bus.rq_IFCMD0[0] = RD; bus.mem_IFRESP0 = ACK; bus.mem_Q0 = 32'hDEADBEEF;
        #1 chk("rd_q", {bus.rq_Q0[0], bus.rq_Q0[1], bus.rq_IFRESP0[1]}, {32'hDEADBEEF, 32'h0, WT});
        step();
        clear_in();
        #1 chk("rd_grant_clear", grant_o, 0);

        // abort in ADDR does not advance the round robin
        bus.rq_REQCMD0[1] = WR;
        step();
        chk("abort_grant", grant_o, 2'b10);
        bus.rq_REQCMD0[1] = 3'd0;
        #1 chk("abort_mem_cmd", bus.mem_REQCMD0, 0);
        step();
        chk("abort_idle", grant_o, 0);
        bus.rq_REQCMD0[0] = WR; bus.rq_REQCMD0[1] = WR;
        bus.rq_D0[0] = 32'h11; bus.rq_D0[1] = 32'h22;
        step();
        chk("abort_regrant", grant_o, 2'b10);
        bus.mem_REQRESP0 = ACK;
        step();
        bus.mem_REQRESP0 = WT; bus.rq_OFCMD0[1] = WR;
        #1 chk("pre_reset_wr", bus.mem_OFCMD0, WR);

        // asynchronous reset in DATA_WR
        bus.mem_OFRESP0 = ACK; bus.mem_Q0 = 32'h1234_5678;
        RST = 1'b1;
        #1;
        chk("async_rst_a", {grant_o, timeout_o, bus.mem_REQCMD0, bus.mem_IFCMD0, bus.mem_OFCMD0, bus.mem_D0, bus.mem_A0}, 0);
        chk("async_rst_b", {bus.rq_REQRESP0, bus.rq_IFRESP0, bus.rq_OFRESP0, bus.rq_Q0}, 0);
        step();
        step();
        bus.mem_OFRESP0 = WT; bus.mem_Q0 = '0; bus.rq_OFCMD0 = '0;
        RST = 1'b0;
        step();

        // conflict: both WRITE, rq0 first after reset
        chk("conf_grant0", grant_o, 2'b01);
        bus.mem_REQRESP0 = ACK;
        #1 chk("conf_resp", {bus.rq_REQRESP0[0], bus.rq_REQRESP0[1]}, {ACK, WT});
        step();
        bus.mem_REQRESP0 = WT; bus.rq_REQCMD0[0] = 3'd0; bus.rq_OFCMD0[0] = WR; bus.mem_OFRESP0 = ACK;
        #1 chk("conf_d0", {bus.mem_D0, bus.rq_OFRESP0[1]}, {32'h11, WT});
        step();
        bus.rq_OFCMD0[0] = 3'd0; bus.mem_OFRESP0 = WT;
        #1 chk("conf_gap", grant_o, 0);
        step();
        chk("conf_grant1", grant_o, 2'b10);
        bus.mem_REQRESP0 = ACK;
        step();
        bus.mem_REQRESP0 = WT; bus.rq_REQCMD0[1] = 3'd0; bus.rq_OFCMD0[1] = WR; bus.mem_OFRESP0 = ACK;
        #1 chk("conf_d1", bus.mem_D0, 32'h22);
        step();
        clear_in();

        // memory never ACKs a read
        bus.rq_A0[0] = 32'h200; bus.rq_REQCMD0[0] = RD;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
`ifdef MEM_ARB_TIMEOUT_EN
            if (k == 8) begin
                chk("to_expire", {timeout_o, bus.rq_REQRESP0[0], bus.mem_REQCMD0}, {1'b1, ERR, 3'd0});
            end else begin
                chk($sformatf("to_count%0d", k), timeout_o, 0);
            end
`else
            chk($sformatf("no_to%0d", k), {timeout_o, bus.rq_REQRESP0[0], grant_o}, {1'b0, WT, 2'b01});
`endif
        end
`ifdef MEM_ARB_TIMEOUT_EN
        bus.rq_REQCMD0[0] = 3'd0;
        step();
        chk("to_idle", {grant_o, timeout_o}, 0);
`else
        bus.rq_REQCMD0[0] = 3'd0;
        step();
        chk("no_to_abort", grant_o, 0);
`endif
        clear_in();
        step();

        // randomized traffic against a transaction-level model
        for (int i = 0; i < N; i++) begin
            ph[i] = 0; raddr[i] = '0; rdata[i] = '0; rcmd[i] = '0; wait_cnt[i] = 0; others[i] = 0;
            for (int w = 0; w < 8; w++) begin
                rmod[i][w] = 32'hA500_0000 | (32'(i) << 8) | 32'(w);
                mmem[i][w] = rmod[i][w];
            end
        end
        lat_a = -1; lat_d = -1; m_addr = '0; stop_rand = 1'b0;
        for (int cyc = 0; cyc < 1500 && !stop_rand; cyc++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (ph[i] == 0 && $urandom_range(0, 2) == 0) begin
                    ph[i] = 1;
                    rcmd[i] = ($urandom_range(0, 1) == 1) ? WR : RD;
                    word[i] = $urandom_range(0, 7);
                    raddr[i] = (32'(i) << 28) | (32'(word[i]) << 2);
                    rdata[i] = (32'(i) << 28) | ($urandom() & 32'h0FFF_FFFF);
                    wait_cnt[i] = 0; others[i] = 0;
                end
                bus.rq_REQCMD0[i] = (ph[i] == 1) ? rcmd[i] : 3'd0;
                bus.rq_A0[i] = raddr[i];
                bus.rq_D0[i] = rdata[i];
                bus.rq_IFCMD0[i] = (ph[i] == 2 && rcmd[i] == RD) ? RD : 3'd0;
                bus.rq_OFCMD0[i] = (ph[i] == 2 && rcmd[i] == WR) ? WR : 3'd0;
            end
            #1;
            bus.mem_REQRESP0 = ($urandom_range(0, 3) == 0) ? ACK : WT;
            bus.mem_IFRESP0 = ($urandom_range(0, 3) == 0) ? ACK : WT;
            bus.mem_OFRESP0 = ($urandom_range(0, 3) == 0) ? ACK : WT;
            bus.mem_Q0 = $urandom();
            if (bus.mem_REQCMD0 != 3'd0) begin
                bus.mem_REQRESP0 = WT;
                if (lat_a < 0) lat_a = $urandom_range(0, 2);
                if (lat_a == 0) begin
                    bus.mem_REQRESP0 = ACK; m_addr = bus.mem_A0; lat_a = -1;
                end else lat_a--;
            end
            if (bus.mem_IFCMD0 == RD) begin
                bus.mem_IFRESP0 = WT;
                if (lat_d < 0) lat_d = $urandom_range(0, 2);
                if (lat_d == 0) begin
                    bus.mem_IFRESP0 = ACK; lat_d = -1;
                    bus.mem_Q0 = mmem[int'(m_addr[31:28]) % N][m_addr[4:2]];
                end else lat_d--;
            end
            if (bus.mem_OFCMD0 == WR) begin
                bus.mem_OFRESP0 = WT;
                if (lat_d < 0) lat_d = $urandom_range(0, 2);
                if (lat_d == 0) begin
                    bus.mem_OFRESP0 = ACK; lat_d = -1;
                    chk("rand_wr_owner", bus.mem_D0[31:28], m_addr[31:28]);
                    mmem[int'(m_addr[31:28]) % N][m_addr[4:2]] = bus.mem_D0;
                end else lat_d--;
            end
            @(negedge CLK);
            chk("rand_onehot", $onehot0(grant_o), 1);
            for (int i = 0; i < N; i++) begin
                if (ph[i] == 0) begin
                    chk($sformatf("rand_idle_rq%0d", i),
                        {bus.rq_REQRESP0[i], bus.rq_IFRESP0[i], bus.rq_OFRESP0[i], bus.rq_Q0[i]}, 0);
                end else begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > 40) begin
                        chk($sformatf("rand_timeout_rq%0d", i), wait_cnt[i], 40);
                        stop_rand = 1'b1;
                    end
                    if (ph[i] == 1) begin
                        chk($sformatf("rand_addr_rq%0d", i), {bus.rq_IFRESP0[i], bus.rq_OFRESP0[i], bus.rq_Q0[i]}, 0);
                        if (bus.rq_REQRESP0[i] == ACK) begin
                            chk($sformatf("rand_fair_rq%0d", i), others[i] <= N - 1, 1);
                            ph[i] = 2;
                        end else begin
                            chk($sformatf("rand_reqresp_rq%0d", i), bus.rq_REQRESP0[i], WT);
                        end
                    end else begin
                        chk($sformatf("rand_data_reqresp_rq%0d", i), bus.rq_REQRESP0[i], WT);
                        if ((rcmd[i] == RD && bus.rq_IFRESP0[i] == ACK) ||
                            (rcmd[i] == WR && bus.rq_OFRESP0[i] == ACK)) begin
                            if (rcmd[i] == RD)
                                chk($sformatf("rand_rd_q_rq%0d", i), bus.rq_Q0[i], rmod[i][word[i]]);
                            else
                                rmod[i][word[i]] = rdata[i];
                            ph[i] = 0;
                            for (int j = 0; j < N; j++)
                                if (j != i && ph[j] == 1) others[j]++;
                        end
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/codasip_memory_mem_rw_arbiter.md
Name: codasip_memory_mem_rw_arbiter

Overview:
- Round-robin arbiter that shares the single read_write port of memory 'mem' between NUM_REQ requesters, such as the load/store unit and a debug/DMA master.
- Each transaction is locked to one requester from address phase through data phase.
- Sits between the requesters and the memory's read_write_* pins.
- Uses the same REQ/IF/OF command-response protocol on both sides.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- TIMEOUT_CYCLES, 64: watchdog limit in cycles. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
rq_A0  in  NUM_REQ x 32  requester addresses
rq_SI0  in  NUM_REQ x 2  requester access size
rq_SC0  in  NUM_REQ x 3  requester access qualifiers
rq_REQCMD0  in  NUM_REQ x 3  requester request command
rq_REQRESP0  out  NUM_REQ x 3  request response per requester
rq_IFCMD0  in  NUM_REQ x 3  read-data command
rq_IFRESP0  out  NUM_REQ x 3  read-data response
rq_Q0  out  NUM_REQ x 32  read data
rq_D0  in  NUM_REQ x 32  write data
rq_OFCMD0  in  NUM_REQ x 3  write-data command
rq_OFRESP0  out  NUM_REQ x 3  write-data response
mem_A0, mem_SI0, mem_SC0, mem_REQCMD0, mem_IFCMD0, mem_D0, mem_OFCMD0  out  32/2/3/3/3/32/3  to memory read_write_* inputs
mem_REQRESP0, mem_IFRESP0, mem_OFRESP0, mem_Q0  in  3/3/3/32  from memory read_write_* outputs
grant_o  out  NUM_REQ  one-hot current owner; 0 when idle
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Encodings:
  - Commands: CMD_IDLE=0, CMD_READ=1, CMD_WRITE=2.
  - Responses: RESP_WAIT=0, RESP_ACK=1, RESP_ERR=2.
- FSM states: IDLE, ADDR, DATA_RD, DATA_WR.
- IDLE:
  - If any rq_REQCMD0 != IDLE, pick the winner by round robin, starting at last_grant+1 modulo NUM_REQ.
  - Register the one-hot grant and the command type, then go to ADDR.
  - Arbitration is always registered: a request sampled in cycle N drives mem_REQCMD0 in cycle N+1.
- ADDR:
  - mem_A0/SI0/SC0/REQCMD0 are combinational copies of the granted requester's inputs.
  - mem_REQRESP0 is routed to that requester's rq_REQRESP0.
  - On RESP_ACK, go to DATA_RD (READ) or DATA_WR (WRITE).
  - If the granted rq_REQCMD0 returns to IDLE before the ACK, abort to IDLE and do not update last_grant.
- DATA_RD:
  - Route the granted rq_IFCMD0 to mem_IFCMD0.
  - Route mem_IFRESP0 and mem_Q0 to the granted requester.
  - On IFRESP ACK, update last_grant and go to IDLE.
- DATA_WR: same as DATA_RD using OFCMD0, D0 and OFRESP0.
- Non-granted requesters:
  - All responses read RESP_WAIT and Q0 reads 0.
  - Their held commands stay pending; no request is ever dropped.
- No back-to-back grant: there is at least one IDLE cycle between transactions. Worst-case wait is NUM_REQ transactions.
- Memory responses that arrive outside their matching phase are ignored.
- Reset (asynchronous, any state, including mid-transaction):
  - State IDLE, grant_o=0, last_grant=NUM_REQ-1 (so rq0 wins first), timeout_o=0.
  - All mem_* outputs 0, all rq responses WAIT, rq_Q0=0.
  - An interrupted transaction is lost; requesters re-issue it.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ADDR/DATA_* and increments each cycle spent in ADDR/DATA_*.
  - When it reaches TIMEOUT_CYCLES without an ACK, the granted requester receives RESP_ERR for one cycle on the active phase's response.
  - All mem commands are forced to IDLE that cycle, timeout_o pulses, last_grant updates, and the FSM goes to IDLE.
- Without the macro: no counter, timeout_o tied 0, RESP_ERR never generated.

Decomposition:
- Package codasip_memory_mem_arb_pkg holds:
  - cmd_e and resp_e enums.
  - state_e.
  - address/data width constants.
- One sub-module, codasip_rr_picker: combinational round-robin one-hot select from a request vector and last_grant.

Test Plan:
- Read: rq0 READ A0=0x100 with mem ACK after 2 cycles and Q0=0xDEADBEEF → mem_REQCMD0=READ one cycle after the request; rq0 receives Q0=0xDEADBEEF; grant_o returns to 0.
- Conflict: rq0 and rq1 both WRITE in the same cycle, with D0=0x11 and 0x22 → memory sees 0x11 then 0x22; rq1 sees only WAIT until its grant.
- Fairness: rq0 and rq1 continuously requesting for 6 transactions → grant sequence 0,1,0,1,0,1.
- Abort: rq1 drops REQCMD0 in ADDR before the ACK → FSM returns to IDLE; next grant still goes to rq1 if it re-requests.
- Reset: RST asserted in DATA_WR → all outputs go to reset values immediately (asynchronously); after release, rq0 wins first.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): memory never ACKs a READ → RESP_ERR to the requester and timeout_o=1 eight cycles after ADDR entry; FSM is back in IDLE the next cycle.
